// File: rtl/mem_req_scheduler.sv
// Shares one memory-controller port between the icache, dcache and page-table walker.
// Fixed priority ptw > dcache > icache, with per-requester aging to prevent starvation.
module mem_req_scheduler #(
    parameter int ADDR_W       = 64,
    parameter int BLOCKSZ      = 512,
    parameter int STARVE_LIMIT = 4,
    parameter int AGE_W        = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ic_req,
    input  logic [ADDR_W-1:0]  ic_addr,
    output logic               ic_done,
    output logic [BLOCKSZ-1:0] ic_data,
    input  logic               dc_req,
    input  logic               dc_wr_en,
    input  logic [ADDR_W-1:0]  dc_addr,
    input  logic [BLOCKSZ-1:0] dc_wdata,
    output logic               dc_done,
    output logic [BLOCKSZ-1:0] dc_data,
    input  logic               pw_req,
    input  logic [ADDR_W-1:0]  pw_addr,
    output logic               pw_done,
    output logic [BLOCKSZ-1:0] pw_data,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_address,
    output logic               mem_wr_en,
    output logic [BLOCKSZ-1:0] mem_data_out,
    input  logic [BLOCKSZ-1:0] data_from_mem,
    input  logic               mem_data_valid,
    output logic               busy,
    output logic [1:0]         grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0]       ID_IC   = 2'd1;
    localparam logic [1:0]       ID_DC   = 2'd2;
    localparam logic [1:0]       ID_PW   = 2'd3;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    state_t            state, state_nxt;
    logic [AGE_W-1:0]  age [3];          // index 0 = icache, 1 = dcache, 2 = ptw
    logic [2:0]        reqs, starved, cand;
    logic [1:0]        win_id;
    logic [ADDR_W-1:0] win_addr;

    assign reqs = {pw_req, dc_req, ic_req};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        starved  = '0;
        cand     = '0;
        win_id   = '0;
        win_addr = '0;
        for (int i = 0; i < 3; i++)
            starved[i] = reqs[i] && (age[i] == AGE_MAX);
        cand = (|starved) ? starved : reqs;
        if (cand[2]) begin
            win_id   = ID_PW;
            win_addr = pw_addr;
        end else if (cand[1]) begin
            win_id   = ID_DC;
            win_addr = dc_addr;
        end else if (cand[0]) begin
            win_id   = ID_IC;
            win_addr = ic_addr;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|reqs) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (mem_data_valid) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // The data registers are architecturally visible outputs, so they are reset along with control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id     <= '0;
            mem_address  <= '0;
            mem_wr_en    <= 1'b0;
            mem_data_out <= '0;
            ic_data      <= '0;
            dc_data      <= '0;
            pw_data      <= '0;
            for (int i = 0; i < 3; i++) age[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    for (int i = 0; i < 3; i++) begin
                        if (!reqs[i] || win_id == 2'(i + 1))
                            age[i] <= '0;
                        else if (age[i] != AGE_MAX)
                            age[i] <= age[i] + 1'b1;
                    end
                    if (|reqs) begin
                        grant_id    <= win_id;
                        mem_address <= {win_addr[ADDR_W-1:6], 6'b0};
                        mem_wr_en   <= (win_id == ID_DC) && dc_wr_en;
                        // Reads leave the write-data bus untouched.
                        if (win_id == ID_DC && dc_wr_en)
                            mem_data_out <= dc_wdata;
                    end
                end
                WAIT: begin
                    if (mem_data_valid && !mem_wr_en) begin
                        case (grant_id)
                            ID_IC:   ic_data <= data_from_mem;
                            ID_DC:   dc_data <= data_from_mem;
                            ID_PW:   pw_data <= data_from_mem;
                            default: ;
                        endcase
                    end
                end
                RESP:    grant_id <= '0;
                default: ;
            endcase
        end
    end

    assign mem_req = (state == ISSUE) || (state == WAIT);
    assign busy    = (state != IDLE);
    assign ic_done = (state == RESP) && (grant_id == ID_IC);
    assign dc_done = (state == RESP) && (grant_id == ID_DC);
    assign pw_done = (state == RESP) && (grant_id == ID_PW);

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Scoreboard bench for mem_req_scheduler: expected grants are queued as requests are
// raised and checked against the memory port and the done/data returns.
module tb_mem_req_scheduler;

    localparam int AW = 64;
    localparam int BW = 512;

    typedef struct {
        logic [1:0]    id;
        logic [AW-1:0] addr;
        logic          wr;
        logic [BW-1:0] wdata;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_req, dc_req, pw_req;
    logic [AW-1:0] ic_addr, dc_addr, pw_addr;
    logic          dc_wr_en;
    logic [BW-1:0] dc_wdata;
    logic          ic_done, dc_done, pw_done;
    logic [BW-1:0] ic_data, dc_data, pw_data;
    logic          mem_req, mem_wr_en, mem_data_valid, busy;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_data_out, data_from_mem;
    logic [1:0]    grant_id;

    int vectors = 0;
    int miscompares = 0;

    // Each requester holds req while it has outstanding requests (target > served).
    int ic_tgt = 0, dc_tgt = 0, pw_tgt = 0;
    int ic_served = 0, dc_served = 0, pw_served = 0;
    assign ic_req = (ic_served < ic_tgt);
    assign dc_req = (dc_served < dc_tgt);
    assign pw_req = (pw_served < pw_tgt);

    bit mem_en = 1'b1;
    int mem_lat = 3;
    int stray_req = 0, stray_done = 0;

    txn_t          exp_q[$];
    txn_t          cur;
    bit            cur_v = 1'b0;
    logic          mem_req_q;
    logic [BW-1:0] last_wdata;

    mem_req_scheduler #(.ADDR_W(AW), .BLOCKSZ(BW), .STARVE_LIMIT(4), .AGE_W(3)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
        .dc_req(dc_req), .dc_wr_en(dc_wr_en), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_done(dc_done), .dc_data(dc_data),
        .pw_req(pw_req), .pw_addr(pw_addr), .pw_done(pw_done), .pw_data(pw_data),
        .mem_req(mem_req), .mem_address(mem_address), .mem_wr_en(mem_wr_en),
        .mem_data_out(mem_data_out), .data_from_mem(data_from_mem),
        .mem_data_valid(mem_data_valid), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] blk(input logic [AW-1:0] a);
        if (a == 64'h0000_0000_8000_1200) return {64{8'hA5}};
        return {8{a ^ 64'h5A5A_0000_0000_0000}};
    endfunction

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return {a[AW-1:6], 6'b0};
    endfunction

    task automatic push(input logic [1:0] id, input logic [AW-1:0] a, input logic wr,
                        input logic [BW-1:0] wd);
        txn_t t;
        t.id = id; t.addr = align(a); t.wr = wr; t.wdata = wd;
        exp_q.push_back(t);
    endtask

    // Memory controller model: answers each request mem_lat cycles after it rises.
    initial begin
        int cnt;
        cnt = 0;
        mem_data_valid = 1'b0;
        data_from_mem  = '0;
        forever begin
            @(negedge clk);
            mem_data_valid = 1'b0;
            if (stray_req != stray_done) begin
                mem_data_valid = 1'b1;
                data_from_mem  = {16{32'hBAD0_BAD0}};
                stray_done++;
            end else if (mem_en && mem_req && !rst) begin
                cnt++;
                if (cnt == mem_lat) begin
                    mem_data_valid = 1'b1;
                    data_from_mem  = blk(mem_address);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Scoreboard monitor: pops a transaction when mem_req rises, checks the port while it
    // is held, and checks the done/data return against it.
    initial begin
        int            n_done;
        logic [1:0]    d_id;
        logic [BW-1:0] d_data;
        mem_req_q  = 1'b0;
        last_wdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                cur_v      = 1'b0;
                last_wdata = '0;
                mem_req_q  = 1'b0;
            end else begin
                if (mem_req && !mem_req_q) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_grant: got grant_id=%0d, expected no grant", grant_id);
                    end else begin
                        cur   = exp_q.pop_front();
                        cur_v = 1'b1;
                        if (cur.wr) last_wdata = cur.wdata;
                    end
                end
                if (mem_req && cur_v) begin
                    vectors++;
                    if (grant_id !== cur.id || mem_address !== cur.addr ||
                        mem_wr_en !== cur.wr || mem_data_out !== last_wdata) begin
                        miscompares++;
                        $display("FAIL mem_port: got id=%0d addr=%h wr=%b wdata[63:0]=%h, expected id=%0d addr=%h wr=%b wdata[63:0]=%h",
                                 grant_id, mem_address, mem_wr_en, mem_data_out[63:0],
                                 cur.id, cur.addr, cur.wr, last_wdata[63:0]);
                    end
                end
                n_done = int'(ic_done) + int'(dc_done) + int'(pw_done);
                if (n_done != 0) begin
                    d_id   = pw_done ? 2'd3 : dc_done ? 2'd2 : 2'd1;
                    d_data = pw_done ? pw_data : dc_done ? dc_data : ic_data;
                    vectors++;
                    if (!cur_v || n_done != 1 || d_id !== cur.id ||
                        (!cur.wr && d_data !== blk(cur.addr))) begin
                        miscompares++;
                        $display("FAIL done: got id=%0d count=%0d data[63:0]=%h, expected id=%0d count=1 data[63:0]=%h (txn open=%b)",
                                 d_id, n_done, d_data[63:0], cur.id, blk(cur.addr) & 512'hFFFF_FFFF_FFFF_FFFF, cur_v);
                    end
                    cur_v = 1'b0;
                    if (ic_done) ic_served++;
                    if (dc_done) dc_served++;
                    if (pw_done) pw_served++;
                end
                mem_req_q = mem_req;
            end
        end
    end

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || cur_v || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s_timeout: got %0d pending after %0d cycles, expected 0", name, exp_q.size(), budget);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        vectors++;
        if ({mem_req, busy, grant_id, ic_done, dc_done, pw_done, mem_wr_en} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got req=%b busy=%b gid=%0d dones=%b%b%b wr=%b, expected all 0",
                     mem_req, busy, grant_id, ic_done, dc_done, pw_done, mem_wr_en);
        end
        vectors++;
        if (mem_address !== '0 || mem_data_out !== '0) begin
            miscompares++;
            $display("FAIL reset_mem_bus: got addr=%h wdata[63:0]=%h, expected 0", mem_address, mem_data_out[63:0]);
        end
        vectors++;
        if (ic_data !== '0 || dc_data !== '0 || pw_data !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got ic=%h dc=%h pw=%h (low 64), expected 0", ic_data[63:0], dc_data[63:0], pw_data[63:0]);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read;
        int n;
        mem_lat = 5;
        ic_addr = 64'h0000_0000_8000_1234;
        push(2'd1, ic_addr, 1'b0, '0);
        ic_tgt = ic_served + 1;
        @(posedge clk);
        #1;
        vectors++;
        if (mem_req !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_latency: got mem_req=%b busy=%b, expected 1 1", mem_req, busy);
        end
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!mem_data_valid && n < 30);
        #1;
        vectors++;
        if (ic_done !== 1'b1 || ic_data !== {64{8'hA5}}) begin
            miscompares++;
            $display("FAIL done_latency: got ic_done=%b ic_data[63:0]=%h, expected 1 a5a5a5a5a5a5a5a5", ic_done, ic_data[63:0]);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (ic_done !== 1'b0 || ic_data !== {64{8'hA5}} || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse_width: got ic_done=%b busy=%b ic_data[63:0]=%h, expected 0 0 a5a5a5a5a5a5a5a5",
                     ic_done, busy, ic_data[63:0]);
        end
        wait_idle("single_read", 40);
        mem_lat = 3;
    endtask

    task automatic test_all_three;
        @(negedge clk);
        ic_addr  = 64'h0000_0000_0000_1040;
        dc_addr  = 64'h0000_0000_0002_2080;
        pw_addr  = 64'h0000_0000_0003_30FF;
        dc_wr_en = 1'b0;
        push(2'd3, pw_addr, 1'b0, '0);
        push(2'd2, dc_addr, 1'b0, '0);
        push(2'd1, ic_addr, 1'b0, '0);
        ic_tgt = ic_served + 1;
        dc_tgt = dc_served + 1;
        pw_tgt = pw_served + 1;
        wait_idle("all_three", 100);
    endtask

    task automatic test_aging;
        int pw0;
        int dc0;
        @(negedge clk);
        dc_addr  = 64'h0000_0000_0004_4000;
        pw_addr  = 64'h0000_0000_0005_5000;
        dc_wr_en = 1'b0;
        for (int i = 0; i < 11; i++)
            push((i == 4 || i == 9) ? 2'd2 : 2'd3, (i == 4 || i == 9) ? dc_addr : pw_addr, 1'b0, '0);
        pw0 = pw_served;
        dc0 = dc_served;
        pw_tgt = pw_served + 9;
        dc_tgt = dc_served + 2;
        wait_idle("aging", 300);
        vectors++;
        if (pw_served - pw0 != 9 || dc_served - dc0 != 2) begin
            miscompares++;
            $display("FAIL aging_counts: got pw=%0d dc=%0d, expected pw=9 dc=2", pw_served - pw0, dc_served - dc0);
        end
    endtask

    task automatic test_writeback;
        logic [BW-1:0] pat;
        @(negedge clk);
        for (int i = 0; i < BW / 32; i++) pat[i*32 +: 32] = $urandom;
        dc_addr  = 64'h0000_0000_0006_6123;
        dc_wdata = pat;
        dc_wr_en = 1'b1;
        mem_lat  = 4;
        push(2'd2, dc_addr, 1'b1, pat);
        dc_tgt = dc_served + 1;
        wait_idle("writeback", 40);
        dc_wr_en = 1'b0;
        dc_wdata = '0;
        ic_addr  = 64'h0000_0000_0007_7000;
        push(2'd1, ic_addr, 1'b0, '0);
        ic_tgt = ic_served + 1;
        wait_idle("read_after_write", 40);
        mem_lat = 3;
    endtask

    task automatic test_stray_and_drop;
        int ic0;
        int n;
        @(negedge clk);
        stray_req++;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_valid: got busy=%b mem_req=%b, expected 0 0", busy, mem_req);
        end
        ic0     = ic_served;
        mem_lat = 6;
        ic_addr = 64'h0000_0000_0008_8040;
        push(2'd1, ic_addr, 1'b0, '0);
        ic_tgt = ic_served + 1;
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        ic_tgt = ic_served;
        wait_idle("drop_during_wait", 40);
        vectors++;
        if (ic_served - ic0 != 1) begin
            miscompares++;
            $display("FAIL dropped_req_done: got %0d ic_done pulses, expected 1", ic_served - ic0);
        end
        mem_lat = 3;
    endtask

    task automatic test_reset_mid_wait;
        int n;
        @(negedge clk);
        mem_en   = 1'b0;
        dc_addr  = 64'h0000_0000_0009_9000;
        dc_wdata = {16{32'h1357_9BDF}};
        dc_wr_en = 1'b1;
        push(2'd2, dc_addr, 1'b1, dc_wdata);
        dc_tgt = dc_served + 1;
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (mem_req !== 1'b1 || busy !== 1'b1 || grant_id !== 2'd2 || mem_wr_en !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_hold: got req=%b busy=%b gid=%0d wr=%b, expected 1 1 2 1", mem_req, busy, grant_id, mem_wr_en);
        end
        #2;
        rst    = 1'b1;
        dc_tgt = dc_served;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 || dc_done !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got req=%b busy=%b gid=%0d dc_done=%b, expected 0 0 0 0", mem_req, busy, grant_id, dc_done);
        end
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 || dc_done !== 1'b0 ||
            mem_wr_en !== 1'b0 || mem_data_out !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_wait: got req=%b busy=%b gid=%0d dc_done=%b wr=%b wdata[63:0]=%h, expected all 0",
                     mem_req, busy, grant_id, dc_done, mem_wr_en, mem_data_out[63:0]);
        end
        @(negedge clk);
        rst      = 1'b0;
        mem_en   = 1'b1;
        dc_wr_en = 1'b0;
        @(negedge clk);
        ic_addr = 64'h0000_0000_000A_A000;
        push(2'd1, ic_addr, 1'b0, '0);
        ic_tgt = ic_served + 1;
        wait_idle("recovery_read", 40);
    endtask

    initial begin
        ic_addr  = '0;
        dc_addr  = '0;
        pw_addr  = '0;
        dc_wr_en = 1'b0;
        dc_wdata = '0;
        test_reset();
        test_single_read();
        test_all_three();
        test_aging();
        test_writeback();
        test_stray_and_drop();
        test_reset_mid_wait();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 ns, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
